nn_train_ctrl: RTL
==================

NN_TRAIN_CTRL -- requirements
Module: nn_train_ctrl

Interface
- REQ-001 SHALL have parameter N_SAMPLES, default 4, meaning training samples per epoch (legal range 1..256).
- REQ-002 SHALL have parameter N_EPOCHS, default 1000, meaning epochs per run (legal range 1..65535).
- REQ-003 SHALL have parameter FWD_CYC, default 3, meaning forward-pass cycles per sample (legal range 1..15).
- REQ-004 SHALL have parameter BWD_CYC, default 4, meaning backward-pass/delta cycles per sample (legal range 1..15).
- REQ-005 SHALL have port clk, input, 1 bit: clock; all logic SHALL be on its rising edge.
- REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-007 SHALL have port start, input, 1 bit: level-sampled request to begin a run.
- REQ-008 SHALL have port abort, input, 1 bit: level-sampled request to stop a run.
- REQ-009 SHALL have port select_initial, output, 1 bit: load-initial-value strobe to all weight registers.
- REQ-010 SHALL have port select_update, output, 1 bit: add-delta strobe to all weight registers.
- REQ-011 SHALL have port fwd_en, output, 1 bit: forward-pass enable.
- REQ-012 SHALL have port bwd_en, output, 1 bit: backward-pass enable.
- REQ-013 SHALL have port sample_idx, output, max(1,clog2(N_SAMPLES)) bits: current sample index.
- REQ-014 SHALL have port epoch_cnt, output, 16 bits unsigned: completed epochs.
- REQ-015 SHALL have port busy, output, 1 bit: run in progress.
- REQ-016 SHALL have port done, output, 1 bit: run-complete pulse.

Function
- REQ-017 SHALL implement FSM states IDLE, INIT, FWD, BWD, UPD, FIN; all outputs SHALL be Moore decodes of the registered state and counters.
- REQ-018 IDLE: start=1 and abort=0 -> INIT next cycle; otherwise stay in IDLE.
- REQ-019 INIT (1 cycle): select_initial=1; sample_idx, epoch_cnt and the phase counter SHALL be cleared; next state FWD.
- REQ-020 FWD: fwd_en=1 for exactly FWD_CYC consecutive cycles; next state BWD.
- REQ-021 BWD: bwd_en=1 for exactly BWD_CYC consecutive cycles; next state UPD.
- REQ-022 UPD: select_update=1 for exactly one cycle per sample, since weight registers accumulate on every cycle the strobe is high.
- REQ-023 On leaving UPD with sample_idx < N_SAMPLES-1: sample_idx SHALL increment by 1; next state FWD.
- REQ-024 On leaving UPD with sample_idx = N_SAMPLES-1: sample_idx SHALL wrap to 0 and epoch_cnt SHALL increment by 1.
- REQ-025 After the REQ-024 increment, next state SHALL be FIN if the new epoch_cnt = N_EPOCHS, else FWD.
- REQ-026 FIN (1 cycle): done=1; next state IDLE; epoch_cnt SHALL hold N_EPOCHS until the next INIT.
- REQ-027 busy SHALL be 1 in INIT, FWD, BWD and UPD, and 0 in IDLE and FIN.
- REQ-028 Cycles per sample SHALL equal FWD_CYC+BWD_CYC+1.
- REQ-029 The start-to-done interval SHALL equal 1 + N_SAMPLES*N_EPOCHS*(FWD_CYC+BWD_CYC+1) cycles, with done in the following cycle.
- REQ-030 start while busy, or while in FIN, SHALL be ignored.
- REQ-031 abort=1 in INIT/FWD/BWD/UPD -> IDLE next cycle, with no done pulse; sample_idx and epoch_cnt SHALL hold their values.
- REQ-032 abort sampled during UPD SHALL still leave select_update=1 in that cycle (Moore behaviour); no further strobes SHALL follow.
- REQ-033 abort and start both high in IDLE: abort SHALL win and the block SHALL stay in IDLE.
- REQ-034 At most one of select_initial, select_update, fwd_en, bwd_en SHALL be high in any cycle.

Reset
- REQ-035 reset=1 SHALL have priority over all inputs in any state: next state IDLE.
- REQ-036 During and after reset, all outputs SHALL be 0: select_initial, select_update, fwd_en, bwd_en, sample_idx, epoch_cnt, busy and done.
- REQ-037 Reset mid-run SHALL generate no strobe in the reset cycle or after it; a new start SHALL be required to reissue INIT.

Verification
- REQ-038 Bench SHALL cover: N_SAMPLES=2, N_EPOCHS=2, FWD_CYC=2, BWD_CYC=3, start pulse -> select_initial 1 cycle, then 4 repetitions of fwd_en 2 / bwd_en 3 / select_update 1; sample_idx sequence 0,1,0,1; done 26 cycles after start sampled; epoch_cnt=2.
- REQ-039 Bench SHALL cover: abort during the second BWD cycle of sample 1, epoch 0 -> IDLE next cycle; no select_update; done never high; sample_idx=1, epoch_cnt=0 held.
- REQ-040 Bench SHALL cover: reset asserted in the UPD cycle -> all outputs 0 from the next cycle; a later start -> select_initial pulse and a fresh run.
- REQ-041 Bench SHALL cover: start held high continuously -> exactly one run; after FIN, a new INIT follows in the cycle after IDLE is re-entered.
- REQ-042 Bench SHALL cover: start and abort high together in IDLE -> stay IDLE, busy=0; in every run, count the select_update pulses and check they equal N_SAMPLES*N_EPOCHS.

Source files
------------

// File: rtl/nn_train_ctrl.sv
// rtl/nn_train_ctrl.sv - training-loop sequencer: init, per-sample fwd/bwd/update, epoch counting
module nn_train_ctrl #(
  parameter int N_SAMPLES = 4,
  parameter int N_EPOCHS  = 1000,
  parameter int FWD_CYC   = 3,
  parameter int BWD_CYC   = 4,
  localparam int SW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          select_initial,
  output logic          select_update,
  output logic          fwd_en,
  output logic          bwd_en,
  output logic [SW-1:0] sample_idx,
  output logic [15:0]   epoch_cnt,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_FWD, S_BWD, S_UPD, S_FIN} state_t;

  localparam logic [3:0]    F_LAST = 4'(FWD_CYC - 1);
  localparam logic [3:0]    B_LAST = 4'(BWD_CYC - 1);
  localparam logic [SW-1:0] S_LAST = SW'(N_SAMPLES - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [15:0]   E_TOT  = 16'(N_EPOCHS);

  state_t      state, state_nxt;
  logic [3:0]  phase_cnt;
  logic [15:0] epoch_inc;
  logic        last_sample, last_epoch;

  assign epoch_inc   = epoch_cnt + 16'd1;
  assign last_sample = (sample_idx == S_LAST);
  assign last_epoch  = (epoch_inc == E_TOT);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && !abort) state_nxt = S_INIT;
      S_INIT: state_nxt = abort ? S_IDLE : S_FWD;
      S_FWD: begin
        if (abort)                     state_nxt = S_IDLE;
        else if (phase_cnt == F_LAST)  state_nxt = S_BWD;
      end
      S_BWD: begin
        if (abort)                     state_nxt = S_IDLE;
        else if (phase_cnt == B_LAST)  state_nxt = S_UPD;
      end
      S_UPD: begin
        if (abort)                          state_nxt = S_IDLE;
        else if (last_sample && last_epoch) state_nxt = S_FIN;
        else                                state_nxt = S_FWD;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    select_initial = 1'b0;
    select_update  = 1'b0;
    fwd_en         = 1'b0;
    bwd_en         = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state)
      S_INIT: begin select_initial = 1'b1; busy = 1'b1; end
      S_FWD:  begin fwd_en         = 1'b1; busy = 1'b1; end
      S_BWD:  begin bwd_en         = 1'b1; busy = 1'b1; end
      S_UPD:  begin select_update  = 1'b1; busy = 1'b1; end
      S_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  // Counters are cleared on entry to INIT so the INIT cycle already shows zeros;
  // an aborted UPD leaves them untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_cnt  <= 4'd0;
      sample_idx <= '0;
      epoch_cnt  <= 16'd0;
    end else begin
      if (state_nxt != state)
        phase_cnt <= 4'd0;
      else if (state == S_FWD || state == S_BWD)
        phase_cnt <= phase_cnt + 4'd1;

      if (state == S_IDLE && state_nxt == S_INIT) begin
        sample_idx <= '0;
        epoch_cnt  <= 16'd0;
      end else if (state == S_UPD && !abort) begin
        if (last_sample) begin
          sample_idx <= '0;
          epoch_cnt  <= epoch_inc;
        end else begin
          sample_idx <= sample_idx + S_ONE;
        end
      end
    end
  end

endmodule
